coin_payer: RTL and testbench

Customer-side coin transmitter for the vending-machine state machine. On a single start pulse it converts a requested payment, in 0.5-yuan units, into a paced stream of one-cycle coin pulses on `pi_money_half` and `pi_money_one`. It also counts the `po_cola` and `po_money` responses the machine returns during the transaction. It replaces hand-written random coin stimulus wherever a deterministic, protocol-correct coin source is needed.

---
 rtl/coin_payer.sv | 116 +++++++++++
 tb/tb_coin_payer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/coin_payer.sv
// Deterministic coin source for the vending-machine FSM: converts a payment in
// 0.5-yuan units into paced 1-yuan/0.5-yuan pulses and counts the machine's responses.
module coin_payer #(
  parameter int unsigned COIN_GAP  = 4,
  parameter int unsigned DRAIN_CYC = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pay_start,
  input  logic [3:0] pay_amount,
  input  logic       po_cola,
  input  logic       po_money,
  output logic       pi_money_half,
  output logic       pi_money_one,
  output logic       busy,
  output logic       done,
  output logic [7:0] cola_cnt,
  output logic [7:0] change_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DRAIN} state_t;

  state_t      state;
  logic [3:0]  remaining;
  logic [31:0] cnt;

  logic        accept;
  logic [3:0]  coin_src;
  logic        big_coin;
  logic [3:0]  rem_after;

  // Coin outputs are registered, so the coin for the upcoming SEND cycle is
  // chosen one edge early: from pay_amount on acceptance, from remaining after a GAP.
  // remaining therefore holds the post-send balance while in SEND.
  always_comb begin
    accept    = (state == IDLE) && pay_start;
    coin_src  = (state == IDLE) ? pay_amount : remaining;
    big_coin  = (coin_src >= 4'd2);
    rem_after = coin_src - (big_coin ? 4'd2 : 4'd1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      remaining     <= '0;
      cnt           <= '0;
      pi_money_half <= 1'b0;
      pi_money_one  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cola_cnt      <= '0;
      change_cnt    <= '0;
    end else begin
      pi_money_half <= 1'b0;
      pi_money_one  <= 1'b0;
      done          <= 1'b0;

      // A response coincident with acceptance is kept rather than lost.
      if (accept)
        cola_cnt <= {7'd0, po_cola};
      else if (po_cola && (cola_cnt != 8'hFF))
        cola_cnt <= cola_cnt + 8'd1;

      if (accept)
        change_cnt <= {7'd0, po_money};
      else if (po_money && (change_cnt != 8'hFF))
        change_cnt <= change_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (pay_start) begin
            if (pay_amount == 4'd0) begin
              done <= 1'b1;
            end else begin
              state         <= SEND;
              busy          <= 1'b1;
              pi_money_one  <= big_coin;
              pi_money_half <= !big_coin;
              remaining     <= rem_after;
            end
          end
        end
        SEND: begin
          if (remaining == 4'd0) begin
            state <= DRAIN;
            cnt   <= DRAIN_CYC - 32'd1;
          end else begin
            state <= GAP;
            cnt   <= COIN_GAP - 32'd1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state         <= SEND;
            pi_money_one  <= big_coin;
            pi_money_half <= !big_coin;
            remaining     <= rem_after;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_payer.sv
// Directed self-checking bench for coin_payer with default COIN_GAP=4, DRAIN_CYC=8.
module tb_coin_payer;

  localparam int G = 4;
  localparam int D = 8;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       pay_start = 1'b0;
  logic [3:0] pay_amount = 4'd0;
  logic       po_cola = 1'b0;
  logic       po_money = 1'b0;
  logic       pi_money_half;
  logic       pi_money_one;
  logic       busy;
  logic       done;
  logic [7:0] cola_cnt;
  logic [7:0] change_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  coin_payer #(.COIN_GAP(G), .DRAIN_CYC(D)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .pay_start    (pay_start),
    .pay_amount   (pay_amount),
    .po_cola      (po_cola),
    .po_money     (po_money),
    .pi_money_half(pi_money_half),
    .pi_money_one (pi_money_one),
    .busy         (busy),
    .done         (done),
    .cola_cnt     (cola_cnt),
    .change_cnt   (change_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " one"},  8'(pi_money_one),  8'd0);
    chk({tag, " half"}, 8'(pi_money_half), 8'd0);
    chk({tag, " busy"}, 8'(busy),          8'd0);
    chk({tag, " done"}, 8'(done),          8'd0);
  endtask

  // Runs one transaction from acceptance to its done cycle, checking every cycle.
  // Cycle n=1 is the cycle right after the accepting edge.
  task automatic run_txn(input int amt, input int cola_at, input int money_at,
                         input int ign_at, input int exp_cola, input int exp_change);
    int m, n_done, idx;
    logic e_one, e_half;
    m      = (amt + 1) / 2;
    n_done = 2 + (m - 1) * (G + 1) + D;
    pay_amount = 4'(amt);
    pay_start  = 1'b1;
    for (int n = 1; n <= n_done; n++) begin
      @(posedge sys_clk); #1;
      idx    = (n - 1) / (G + 1);
      e_one  = 1'b0;
      e_half = 1'b0;
      if (((n - 1) % (G + 1) == 0) && (idx < m)) begin
        if ((idx == m - 1) && (amt % 2 == 1)) e_half = 1'b1;
        else                                  e_one  = 1'b1;
      end
      chk($sformatf("amt%0d c%0d one", amt, n),  8'(pi_money_one),  8'(e_one));
      chk($sformatf("amt%0d c%0d half", amt, n), 8'(pi_money_half), 8'(e_half));
      chk($sformatf("amt%0d c%0d busy", amt, n), 8'(busy),          8'(n < n_done));
      chk($sformatf("amt%0d c%0d done", amt, n), 8'(done),          8'(n == n_done));
      if (n == 1) begin
        chk($sformatf("amt%0d cola cleared", amt),   cola_cnt,   8'd0);
        chk($sformatf("amt%0d change cleared", amt), change_cnt, 8'd0);
      end
      if (n == n_done) begin
        chk($sformatf("amt%0d cola at done", amt),   cola_cnt,   8'(exp_cola));
        chk($sformatf("amt%0d change at done", amt), change_cnt, 8'(exp_change));
      end
      po_cola  = (n + 1 == cola_at);
      po_money = (n + 1 == money_at);
      if (n + 1 == ign_at) begin
        pay_start  = 1'b1;
        pay_amount = 4'd15;
      end else begin
        pay_start = 1'b0;
      end
    end
  endtask

  initial begin
    // Reset: outputs are 0 while held and stay 0 afterwards without a request.
    #12;
    chk_quiet("rst hold");
    chk("rst cola", cola_cnt, 8'd0);
    chk("rst change", change_cnt, 8'd0);
    #8 sys_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge sys_clk); #1;
      chk_quiet($sformatf("idle c%0d", i));
    end

    // Zero amount: done next cycle, no coins, coincident po_cola kept.
    pay_amount = 4'd0;
    pay_start  = 1'b1;
    po_cola    = 1'b1;
    @(posedge sys_clk); #1;
    pay_start = 1'b0;
    po_cola   = 1'b0;
    chk("zero done", 8'(done), 8'd1);
    chk("zero busy", 8'(busy), 8'd0);
    chk("zero one", 8'(pi_money_one), 8'd0);
    chk("zero half", 8'(pi_money_half), 8'd0);
    chk("zero cola", cola_cnt, 8'd1);
    @(posedge sys_clk); #1;
    chk_quiet("zero after");
    chk("zero cola hold", cola_cnt, 8'd1);

    // 5 units: one@1, one@6, half@11, done@20; one cola response.
    run_txn(5, 14, 0, 0, 1, 0);
    // Back-to-back from the done cycle: 6 units, counters cleared on acceptance.
    run_txn(6, 15, 16, 0, 1, 1);
    // 4 units with an ignored 15-unit start during GAP.
    run_txn(4, 0, 0, 3, 0, 0);

    // Saturation: counters keep counting after done and stop at 255.
    pay_amount = 4'd0;
    po_cola    = 1'b1;
    for (int i = 0; i < 300; i++) @(posedge sys_clk);
    #1;
    po_cola = 1'b0;
    chk("sat cola", cola_cnt, 8'd255);
    chk("sat change", change_cnt, 8'd0);
    @(posedge sys_clk); #1;
    chk("sat cola hold", cola_cnt, 8'd255);

    // Reset between first and second coin of a 4-unit payment.
    pay_amount = 4'd4;
    pay_start  = 1'b1;
    @(posedge sys_clk); #1;
    pay_start = 1'b0;
    chk("mid first coin", 8'(pi_money_one), 8'd1);
    po_cola = 1'b1;
    @(posedge sys_clk); #1;
    po_cola = 1'b0;
    chk("mid busy", 8'(busy), 8'd1);
    chk("mid cola", cola_cnt, 8'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk_quiet("mid async");
    chk("mid async cola", cola_cnt, 8'd0);
    chk("mid async change", change_cnt, 8'd0);
    #20 sys_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge sys_clk); #1;
      chk_quiet($sformatf("post rst c%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
